// File: rtl/seg7_scan_reader.sv
// Reconstructs a 4-digit hex value from a multiplexed 7-segment bus.
// Each digit is stability-filtered; a frame commits once all four are seen.
module seg7_scan_reader #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        p,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        valid
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_COMMIT  = 1'b1;
  localparam logic [7:0] STABLE_C   = 8'(STABLE);

  function automatic logic [4:0] decode7(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [11:0] pins;
  logic [11:0] s_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        same, onehot, accept;
  logic [3:0]  acc_bits;
  logic [4:0]  dec;
  logic [3:0]  seen_q, seen_d;
  logic [0:0]  state_q, state_d;
  logic [3:0]  sh_nib_q [4];
  logic [3:0]  sh_dp_q, sh_err_q;
  logic [15:0] value_q;
  logic [3:0]  dp_q, err_q;
  logic        valid_q;

  assign pins = {dig, a, b, c, d, e, f, g, p};

  // The decision looks at the value S is about to take, so the accept lands
  // on the same edge at which the run reaches STABLE samples.
  assign same   = (pins == s_q);
  assign onehot = (pins[11:8] != 4'd0) && ((pins[11:8] & (pins[11:8] - 4'd1)) == 4'd0);
  assign dec    = decode7(pins[7:1]);

  always_comb begin
    cnt_d = 8'd1;
    if (same) begin
      cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 8'd1;
    end
    done_d   = same & done_q;
    accept   = (cnt_d == STABLE_C) && !done_d && onehot;
    acc_bits = accept ? pins[11:8] : 4'd0;
    seen_d   = ((state_q == ST_COMMIT) ? 4'd0 : seen_q) | acc_bits;
    state_d  = ST_COLLECT;
    if (state_q == ST_COLLECT && seen_d == 4'hF) begin
      state_d = ST_COMMIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      seen_q   <= '0;
      state_q  <= ST_COLLECT;
      sh_dp_q  <= '0;
      sh_err_q <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_nib_q[i] <= '0;
      end
    end else begin
      s_q     <= pins;
      cnt_q   <= cnt_d;
      done_q  <= done_d | accept;
      seen_q  <= seen_d;
      state_q <= state_d;
      valid_q <= (state_q == ST_COMMIT);
      if (state_q == ST_COMMIT) begin
        value_q <= {sh_nib_q[3], sh_nib_q[2], sh_nib_q[1], sh_nib_q[0]};
        dp_q    <= sh_dp_q;
        err_q   <= sh_err_q;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc_bits[i]) begin
          sh_nib_q[i] <= dec[3:0];
          sh_dp_q[i]  <= pins[0];
          sh_err_q[i] <= dec[4];
        end
      end
    end
  end

  assign value = value_q;
  assign dp    = dp_q;
  assign err   = err_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Drives one shared display bus into STABLE=4 and STABLE=1 readers and
// checks both against a run-length/frame reference model every cycle.
module tb_seg7_scan_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig_r;
  logic [6:0] seg_r;
  logic       p_r;

  logic [15:0] value_w [2];
  logic [3:0]  dp_w [2];
  logic [3:0]  err_w [2];
  logic        valid_w [2];

  seg7_scan_reader #(.STABLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .a(seg_r[6]), .b(seg_r[5]), .c(seg_r[4]), .d(seg_r[3]),
    .e(seg_r[2]), .f(seg_r[1]), .g(seg_r[0]), .p(p_r), .dig(dig_r),
    .value(value_w[0]), .dp(dp_w[0]), .err(err_w[0]), .valid(valid_w[0])
  );

  seg7_scan_reader #(.STABLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a(seg_r[6]), .b(seg_r[5]), .c(seg_r[4]), .d(seg_r[3]),
    .e(seg_r[2]), .f(seg_r[1]), .g(seg_r[0]), .p(p_r), .dig(dig_r),
    .value(value_w[1]), .dp(dp_w[1]), .err(err_w[1]), .valid(valid_w[1])
  );

  always #5 clk = ~clk;

  logic [6:0] pat_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int compared = 0;
  int mismatched = 0;

  int          thr [2] = '{4, 1};
  logic [11:0] m_prev;
  int          m_run;
  logic [3:0]  m_nib [2][4];
  logic [3:0]  m_sdp [2];
  logic [3:0]  m_serr [2];
  logic [3:0]  m_seen [2];
  bit          m_pend [2];
  logic [15:0] e_val [2];
  logic [3:0]  e_dp [2];
  logic [3:0]  e_err [2];
  logic        e_valid [2];
  int          pulses [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table lookup: bit 4 flags a pattern that is not in the table.
  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    for (int k = 0; k < 16; k++) begin
      if (pat_tab[k] == seg) return {1'b0, 4'(k)};
    end
    return 5'h10;
  endfunction

  task automatic model_reset();
    m_prev = '0;
    m_run  = 0;
    for (int ii = 0; ii < 2; ii++) begin
      for (int k = 0; k < 4; k++) m_nib[ii][k] = '0;
      m_sdp[ii] = '0; m_serr[ii] = '0; m_seen[ii] = '0; m_pend[ii] = 0;
      e_val[ii] = '0; e_dp[ii] = '0; e_err[ii] = '0; e_valid[ii] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [11:0] pins;
    logic [4:0]  dv;
    pins = {dig_r, seg_r, p_r};
    if (pins == m_prev) m_run++;
    else m_run = 1;
    m_prev = pins;
    dv = ref_decode(seg_r);
    for (int ii = 0; ii < 2; ii++) begin
      e_valid[ii] = 1'b0;
      if (m_pend[ii]) begin
        e_val[ii]   = {m_nib[ii][3], m_nib[ii][2], m_nib[ii][1], m_nib[ii][0]};
        e_dp[ii]    = m_sdp[ii];
        e_err[ii]   = m_serr[ii];
        e_valid[ii] = 1'b1;
        m_seen[ii]  = '0;
        m_pend[ii]  = 0;
      end
      if (m_run == thr[ii] && $countones(dig_r) == 1) begin
        for (int k = 0; k < 4; k++) begin
          if (dig_r[k]) begin
            m_nib[ii][k]  = dv[3:0];
            m_sdp[ii][k]  = p_r;
            m_serr[ii][k] = dv[4];
            m_seen[ii][k] = 1'b1;
          end
        end
      end
      if (m_seen[ii] == 4'hF) m_pend[ii] = 1;
    end
  endtask

  task automatic check_outputs();
    for (int ii = 0; ii < 2; ii++) begin
      check($sformatf("valid[%0d]", ii), 32'(valid_w[ii]), 32'(e_valid[ii]));
      check($sformatf("value[%0d]", ii), 32'(value_w[ii]), 32'(e_val[ii]));
      check($sformatf("dp[%0d]", ii),    32'(dp_w[ii]),    32'(e_dp[ii]));
      check($sformatf("err[%0d]", ii),   32'(err_w[ii]),   32'(e_err[ii]));
      if (valid_w[ii] === 1'b1) pulses[ii]++;
    end
  endtask

  task automatic cyc(input logic [3:0] dg, input logic [6:0] sg, input logic pp, input int n);
    for (int c = 0; c < n; c++) begin
      dig_r = dg; seg_r = sg; p_r = pp;
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    for (int ii = 0; ii < 2; ii++) begin
      check($sformatf("rst_value[%0d]", ii), 32'(value_w[ii]), 32'h0);
      check($sformatf("rst_dp[%0d]", ii),    32'(dp_w[ii]),    32'h0);
      check($sformatf("rst_err[%0d]", ii),   32'(err_w[ii]),   32'h0);
      check($sformatf("rst_valid[%0d]", ii), 32'(valid_w[ii]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_pulses();
    pulses[0] = 0;
    pulses[1] = 0;
  endtask

  initial begin
    logic [3:0] rd;
    logic [6:0] rs;
    int r;
    rst = 1'b0; dig_r = '0; seg_r = '0; p_r = 1'b0;
    clear_pulses();
    #1;
    do_reset();

    // Basic frame 1,2,3,4
    clear_pulses();
    cyc(4'b0001, pat_tab[1], 1'b0, 6);
    cyc(4'b0010, pat_tab[2], 1'b0, 6);
    cyc(4'b0100, pat_tab[3], 1'b0, 6);
    cyc(4'b1000, pat_tab[4], 1'b0, 6);
    $display("basic frame: value4=%h value1=%h pulses=%0d/%0d", value_w[0], value_w[1], pulses[0], pulses[1]);
    check("t1_pulses4", 32'(pulses[0]), 32'd1);
    check("t1_pulses1", 32'(pulses[1]), 32'd1);
    check("t1_value4", 32'(value_w[0]), 32'h4321);
    check("t1_value1", 32'(value_w[1]), 32'h4321);
    check("t1_dp_err4", 32'({dp_w[0], err_w[0]}), 32'h00);

    // Short glitch on digit 2 must not reach the STABLE=4 reader
    clear_pulses();
    cyc(4'b0100, pat_tab[7], 1'b0, 3);
    cyc(4'b0100, pat_tab[14], 1'b0, 6);
    cyc(4'b0001, pat_tab[0], 1'b0, 6);
    cyc(4'b0010, pat_tab[0], 1'b0, 6);
    cyc(4'b1000, pat_tab[0], 1'b0, 6);
    $display("glitch frame: value4=%h pulses=%0d", value_w[0], pulses[0]);
    check("t2_nib2", 32'(value_w[0][11:8]), 32'hE);
    check("t2_pulses4", 32'(pulses[0]), 32'd1);

    // Unrecognised pattern with decimal point on digit 1
    clear_pulses();
    cyc(4'b0001, pat_tab[9], 1'b0, 6);
    cyc(4'b0010, 7'b1010101, 1'b1, 6);
    cyc(4'b0100, pat_tab[12], 1'b0, 6);
    cyc(4'b1000, pat_tab[5], 1'b0, 6);
    $display("invalid frame: value4=%h dp=%b err=%b", value_w[0], dp_w[0], err_w[0]);
    check("t3_value4", 32'(value_w[0]), 32'h5C09);
    check("t3_err4", 32'(err_w[0]), 32'b0010);
    check("t3_dp4", 32'(dp_w[0]), 32'b0010);

    // Blanking and ghosting keep the partial frame and never accept
    clear_pulses();
    cyc(4'b0001, pat_tab[6], 1'b0, 6);
    cyc(4'b0010, pat_tab[7], 1'b0, 6);
    cyc(4'b0000, pat_tab[8], 1'b0, 20);
    cyc(4'b0101, pat_tab[8], 1'b0, 20);
    check("t4_nopulse4", 32'(pulses[0]), 32'd0);
    check("t4_nopulse1", 32'(pulses[1]), 32'd0);
    cyc(4'b0100, pat_tab[11], 1'b0, 6);
    cyc(4'b1000, pat_tab[13], 1'b0, 6);
    $display("blank frame: value4=%h pulses=%0d/%0d", value_w[0], pulses[0], pulses[1]);
    check("t4_value4", 32'(value_w[0]), 32'hDB76);
    check("t4_pulses4", 32'(pulses[0]), 32'd1);

    // Digit 0 overwritten before the frame completes
    clear_pulses();
    cyc(4'b0001, pat_tab[10], 1'b0, 6);
    cyc(4'b0001, pat_tab[15], 1'b0, 6);
    cyc(4'b0010, pat_tab[1], 1'b0, 6);
    cyc(4'b0100, pat_tab[2], 1'b0, 6);
    cyc(4'b1000, pat_tab[3], 1'b0, 6);
    $display("overwrite frame: value4=%h value1=%h", value_w[0], value_w[1]);
    check("t5_value4", 32'(value_w[0]), 32'h321F);
    check("t5_value1", 32'(value_w[1]), 32'h321F);

    // STABLE=1: accept of digit 0 on the commit edge starts the next frame
    clear_pulses();
    cyc(4'b0001, pat_tab[10], 1'b0, 1);
    cyc(4'b0010, pat_tab[1], 1'b0, 1);
    cyc(4'b0100, pat_tab[2], 1'b0, 1);
    cyc(4'b1000, pat_tab[3], 1'b0, 1);
    cyc(4'b0001, pat_tab[5], 1'b0, 1);
    $display("boundary commit: value1=%h valid1=%b", value_w[1], valid_w[1]);
    check("t6_first_valid", 32'(valid_w[1]), 32'd1);
    check("t6_first_value", 32'(value_w[1]), 32'h321A);
    cyc(4'b0010, pat_tab[6], 1'b0, 1);
    cyc(4'b0100, pat_tab[7], 1'b0, 1);
    cyc(4'b1000, pat_tab[8], 1'b0, 2);
    $display("boundary next: value1=%h pulses=%0d", value_w[1], pulses[1]);
    check("t6_second_value", 32'(value_w[1]), 32'h8765);
    check("t6_pulses1", 32'(pulses[1]), 32'd2);

    // Reset mid-frame discards the two digits already captured
    cyc(4'b0001, pat_tab[1], 1'b0, 6);
    cyc(4'b0010, pat_tab[2], 1'b0, 6);
    do_reset();
    clear_pulses();
    cyc(4'b0100, pat_tab[3], 1'b0, 6);
    cyc(4'b1000, pat_tab[4], 1'b0, 6);
    check("t7_nopulse4", 32'(pulses[0]), 32'd0);
    check("t7_nopulse1", 32'(pulses[1]), 32'd0);
    cyc(4'b0001, pat_tab[9], 1'b0, 6);
    cyc(4'b0010, pat_tab[8], 1'b0, 6);
    $display("post-reset frame: value4=%h value1=%h pulses=%0d/%0d", value_w[0], value_w[1], pulses[0], pulses[1]);
    check("t7_pulses4", 32'(pulses[0]), 32'd1);
    check("t7_value4", 32'(value_w[0]), 32'h4389);
    check("t7_value1", 32'(value_w[1]), 32'h4389);

    // Randomized scanning, blanking, ghosting and bad patterns
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 9);
      if (r < 8) rd = 4'(1 << (r % 4));
      else if (r == 8) rd = 4'd0;
      else rd = 4'($urandom);
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom);
      else rs = pat_tab[$urandom_range(0, 15)];
      cyc(rd, rs, 1'($urandom_range(0, 1)), $urandom_range(1, 6));
      if (s == 80) do_reset();
    end
    $display("random phase: value4=%h value1=%h", value_w[0], value_w[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads a four-digit, time-multiplexed 7-segment display bus (segment lines a–g, decimal point p, one-hot digit selects) and reconstructs the displayed hexadecimal value. It is the inverse of the team's binary-to-7-segment decoders: segment patterns go in, and nibbles come out. It sits at the display pins for loopback self-test and for capturing external display boards. Each digit sample is stability-filtered, and a new 16-bit value is committed once all four digits have been captured.

## Interface
- STABLE, 4: consecutive identical registered samples required before a digit is accepted; legal range 1–255.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- a, b, c, d, e, f, g  in  1 each  segment lines, active-high (1 = lit); a top, g middle.
- p  in  1  decimal point, active-high.
- dig  in  4  digit select, active-high; dig[0] = least-significant digit.
- value  out  16  last committed value; value[4i+3:4i] = digit i.
- dp  out  4  last committed decimal points, per digit.
- err  out  4  per-digit flag for an unrecognised pattern in the last committed frame.
- valid  out  1  single-cycle pulse when value/dp/err update.

## Operation
- Input stage: {dig, a..g, p} are registered on every clk edge into the sample register S, with no other logic ahead of it.
- Stability counter: if S equals its previous value, increment with saturation at STABLE; otherwise load 1. An accept-done flag clears whenever S changes.
- Accept condition: counter equals STABLE, accept-done is 0, and dig in S is exactly one-hot. On accept, set accept-done; each stable run is accepted once only.
- dig of 0000 or more than one bit set is treated as blanking or ghosting: never accepted, but still participates in the change detection.
- Pattern decode, with {a,b,c,d,e,f,g} mapped to a nibble:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1111011=9, 1110111=A, 0011111=b
  - 1001110=C, 0111101=d, 1001111=E, 1000111=F
  - Any other pattern gives nibble 0 with the error bit set.
- On accept of digit i: the shadow nibble i, shadow dp[i] (from p) and shadow err[i] are overwritten, and seen[i] is set. Re-accepting a digit before the frame completes overwrites it again.
- State machine:
  - COLLECT → COMMIT when seen becomes 1111.
  - COMMIT (1 cycle): copy shadow to value/dp/err, pulse valid, clear seen, return to COLLECT.
- An accept that occurs during the COMMIT cycle belongs to the new frame: the seen bit is set after the clear, and the shadow is written after the copy.
- Outputs hold their values between commits. Shadow registers are not cleared at commit.

## Timing
- Reset (asynchronous, any time): value=0, dp=0, err=0, valid=0, seen=0, counter=0, accept-done=0, S=0, shadow=0, state=COLLECT. A partial frame in progress is discarded.
- Pins stable from before edge k: S holds them at edge k. With STABLE=N, the accept happens at edge k+N−1, so the shadow updates at that edge.
- If the 4th distinct digit is accepted at edge m: COMMIT happens at edge m+1, where value/dp/err update and valid=1 for exactly that cycle.
- Minimum pin hold time for a digit to be accepted is STABLE cycles. Glitches shorter than that are ignored.
- With STABLE=1, every change of S to a one-hot dig value is accepted immediately.

## Test plan
- STABLE=4. Drive digits 0..3 for 6 cycles each, with patterns for 1, 2, 3, 4 (0110000, 1101101, 1111001, 0110011) and p=0 → exactly one valid pulse; value=16'h4321, dp=0, err=0.
- Glitch rejection: STABLE=4. Drive digit 2 with pattern 7 for 3 cycles, then digit 2 with pattern E for 6 cycles, completing the frame with digits 0, 1, 3 → nibble 2 = E; the glitch pattern 7 never appears.
- Invalid pattern plus dp: digit 1 driven with 1010101 and p=1 → after commit, value[7:4]=0, err=0010, dp=0010.
- Blanking and ghosting: dig=0000 or 0101 held for 20 cycles → no accept, seen unchanged, no valid pulse. A correct frame afterwards commits normally.
- Overwrite and boundary: digit 0 accepted as A, then again as F before the frame completes → committed value[3:0]=F. An accept of digit 0 landing exactly in the COMMIT cycle counts toward the next frame (seen=0001 afterwards).
- Reset mid-frame: rst pulsed after 2 digits are accepted → all outputs 0, no valid pulse. The next full frame requires all 4 digits to be accepted again.
